// File: rtl/term_pkg.sv
// Shared definitions for the character-terminal controller:
// control codes, FSM state encoding and small decode helpers.
package term_pkg;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] TAB = 8'h09;
    localparam logic [7:0] FF  = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        CLEAR,
        SCR_RD,
        SCR_WAIT,
        SCR_WR,
        SCR_CLR
    } state_t;

    // Next tab stop strictly above col, clamped to the last column.
    function automatic int tab_target(int col, int tab_w, int cols);
        int nxt;
        nxt = (col & ~(tab_w - 1)) + tab_w;
        return (nxt > cols - 1) ? cols - 1 : nxt;
    endfunction

    function automatic logic is_ctrl(logic [7:0] c);
        return (c == CR) || (c == LF) || (c == BS) ||
               (c == TAB) || (c == FF);
    endfunction

endpackage

// File: rtl/term_ctrl_cursor.sv
// Cursor position register: applies one movement command per cycle
// and flags when a wrap or line feed must scroll the screen.
module term_cursor
    import term_pkg::*;
#(
    parameter int COLS  = 60,
    parameter int ROWS  = 17,
    parameter int COL_W = 6,
    parameter int ROW_W = 5,
    parameter int TAB_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_home,
    input  logic             i_adv,
    input  logic             i_cr,
    input  logic             i_lf,
    input  logic             i_bs,
    input  logic             i_tab,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_scroll
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_tab_col;
    logic             w_last_row;
    logic             w_last_col;

    assign w_tab_col  = COL_W'(tab_target(int'(r_col), TAB_W, COLS));
    assign w_last_row = (r_row == LAST_ROW);
    assign w_last_col = (r_col == LAST_COL);

    // Scroll is needed when moving down from the bottom row.
    assign o_scroll = w_last_row &&
                      (i_lf || (i_adv && w_last_col));

    assign o_row = r_row;
    assign o_col = r_col;

    // Apply the single active cursor command, if any.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            unique case (1'b1)
                i_home: begin
                    r_row <= '0;
                    r_col <= '0;
                end
                i_adv: begin
                    if (!w_last_col) begin
                        r_col <= r_col + 1'b1;
                    end else begin
                        r_col <= '0;
                        if (!w_last_row)
                            r_row <= r_row + 1'b1;
                    end
                end
                i_cr: r_col <= '0;
                i_lf: begin
                    if (!w_last_row)
                        r_row <= r_row + 1'b1;
                end
                i_bs: begin
                    if (r_col != '0) begin
                        r_col <= r_col - 1'b1;
                    end else if (r_row != '0) begin
                        r_row <= r_row - 1'b1;
                        r_col <= LAST_COL;
                    end
                end
                i_tab: r_col <= w_tab_col;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/term_ctrl.sv
// Character-terminal controller: accepts bytes, interprets control
// codes, writes VRAM and performs in-place clear and scroll.
module term_ctrl
    import term_pkg::*;
#(
    parameter int         COLS  = 60,
    parameter int         ROWS  = 17,
    parameter int         COL_W = 6,
    parameter int         ROW_W = 5,
    parameter int         TAB_W = 8,
    parameter logic [7:0] BLANK = 8'h00
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [7:0]             i_char,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [ROW_W-1:0]       o_row,
    output logic [COL_W-1:0]       o_col,
    output logic                   o_busy,
    output logic [ROW_W+COL_W-1:0] o_vram_addr,
    output logic [7:0]             o_vram_din,
    input  logic [7:0]             i_vram_dout,
    output logic                   o_vram_ce,
    output logic                   o_vram_w
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] PEN_ROW  = ROW_W'(ROWS - 2);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_char;
    logic [7:0]       r_data;
    logic [ROW_W-1:0] r_rcnt;
    logic [COL_W-1:0] r_ccnt;
    logic [ROW_W-1:0] w_src_row;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic             w_put;
    logic             w_print;
    logic             w_scroll;
    logic             w_clr_last;
    logic             w_ccnt_last;

    assign w_put       = (r_state == PUT);
    assign w_print     = !is_ctrl(r_char);
    assign w_src_row   = r_rcnt + 1'b1;
    assign w_ccnt_last = (r_ccnt == LAST_COL);
    assign w_clr_last  = (r_state == CLEAR) &&
                         (r_rcnt == LAST_ROW) && w_ccnt_last;

    term_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W),
        .TAB_W (TAB_W)
    ) u_cursor (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_home   (w_clr_last),
        .i_adv    (w_put && w_print),
        .i_cr     (w_put && (r_char == CR)),
        .i_lf     (w_put && (r_char == LF)),
        .i_bs     (w_put && (r_char == BS)),
        .i_tab    (w_put && (r_char == TAB)),
        .o_row    (w_row),
        .o_col    (w_col),
        .o_scroll (w_scroll)
    );

    assign o_row   = w_row;
    assign o_col   = w_col;
    assign o_ready = (r_state == IDLE);
    assign o_busy  = (r_state == CLEAR) || (r_state == SCR_RD) ||
                     (r_state == SCR_WAIT) || (r_state == SCR_WR) ||
                     (r_state == SCR_CLR);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Accepted byte, scan counters and scroll data latch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_char <= '0;
            r_data <= '0;
            r_rcnt <= '0;
            r_ccnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid)
                        r_char <= i_char;
                end
                PUT: begin
                    r_rcnt <= '0;
                    r_ccnt <= '0;
                end
                CLEAR: begin
                    if (w_ccnt_last) begin
                        r_ccnt <= '0;
                        if (r_rcnt != LAST_ROW)
                            r_rcnt <= r_rcnt + 1'b1;
                    end else begin
                        r_ccnt <= r_ccnt + 1'b1;
                    end
                end
                SCR_WAIT: r_data <= i_vram_dout;
                SCR_WR: begin
                    if (w_ccnt_last) begin
                        r_ccnt <= '0;
                        if (r_rcnt != PEN_ROW)
                            r_rcnt <= r_rcnt + 1'b1;
                    end else begin
                        r_ccnt <= r_ccnt + 1'b1;
                    end
                end
                SCR_CLR: begin
                    if (!w_ccnt_last)
                        r_ccnt <= r_ccnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and VRAM strobes decoded from registered state.
    always_comb begin
        w_next      = r_state;
        o_vram_ce   = 1'b0;
        o_vram_w    = 1'b0;
        o_vram_addr = '0;
        o_vram_din  = '0;
        case (r_state)
            IDLE: begin
                if (i_valid)
                    w_next = PUT;
            end
            PUT: begin
                if (w_print) begin
                    o_vram_ce   = 1'b1;
                    o_vram_w    = 1'b1;
                    o_vram_addr = {w_row, w_col};
                    o_vram_din  = r_char;
                end
                if (r_char == FF)
                    w_next = CLEAR;
                else if (w_scroll)
                    w_next = SCR_RD;
                else
                    w_next = IDLE;
            end
            CLEAR: begin
                o_vram_ce   = 1'b1;
                o_vram_w    = 1'b1;
                o_vram_addr = {r_rcnt, r_ccnt};
                o_vram_din  = BLANK;
                if (w_clr_last)
                    w_next = IDLE;
            end
            SCR_RD: begin
                o_vram_ce   = 1'b1;
                o_vram_addr = {w_src_row, r_ccnt};
                w_next      = SCR_WAIT;
            end
            SCR_WAIT: w_next = SCR_WR;
            SCR_WR: begin
                o_vram_ce   = 1'b1;
                o_vram_w    = 1'b1;
                o_vram_addr = {r_rcnt, r_ccnt};
                o_vram_din  = r_data;
                if (w_ccnt_last && (r_rcnt == PEN_ROW))
                    w_next = SCR_CLR;
                else
                    w_next = SCR_RD;
            end
            SCR_CLR: begin
                o_vram_ce   = 1'b1;
                o_vram_w    = 1'b1;
                o_vram_addr = {LAST_ROW, r_ccnt};
                o_vram_din  = BLANK;
                if (w_ccnt_last)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl on a 4x3 screen with a VRAM
// model and a screen/cursor reference model.
module tb_term_ctrl;

    localparam int C   = 4;
    localparam int R   = 3;
    localparam int TW  = 2;
    localparam int SCR = 3 * C * (R - 1) + C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_char = 8'h00;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [4:0]  o_row;
    logic [5:0]  o_col;
    logic        o_busy;
    logic [10:0] o_vram_addr;
    logic [7:0]  o_vram_din;
    logic [7:0]  vram_dout = 8'h00;
    logic        o_vram_ce;
    logic        o_vram_w;

    term_ctrl #(
        .COLS  (C),
        .ROWS  (R),
        .COL_W (6),
        .ROW_W (5),
        .TAB_W (TW),
        .BLANK (8'h00)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_char      (i_char),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_row       (o_row),
        .o_col       (o_col),
        .o_busy      (o_busy),
        .o_vram_addr (o_vram_addr),
        .o_vram_din  (o_vram_din),
        .i_vram_dout (vram_dout),
        .o_vram_ce   (o_vram_ce),
        .o_vram_w    (o_vram_w)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [2048];
    logic [18:0] wlog [$];
    int          n_strobe = 0;
    int          n_bad = 0;
    int          n_pass = 0;
    int          n_total = 0;

    logic [7:0]  exp_scr [R][C];
    int          mr = 0;
    int          mc = 0;

    // VRAM: synchronous write, read data available the next cycle.
    always @(posedge clk) begin
        if (rst_n && o_vram_ce) begin
            n_strobe <= n_strobe + 1;
            if (o_vram_addr[10:6] >= 5'(R) || o_vram_addr[5:0] >= 6'(C))
                n_bad <= n_bad + 1;
            if (o_vram_w) begin
                mem[o_vram_addr] <= o_vram_din;
                wlog.push_back({o_vram_addr, o_vram_din});
            end else begin
                vram_dout <= mem[o_vram_addr];
            end
        end
    end

    task automatic m_scroll();
        for (int r = 0; r < R - 1; r++)
            for (int c = 0; c < C; c++)
                exp_scr[r][c] = exp_scr[r + 1][c];
        for (int c = 0; c < C; c++)
            exp_scr[R - 1][c] = 8'h00;
    endtask

    // Reference model: returns the expected cycles with o_ready low.
    task automatic m_apply(input logic [7:0] ch, output int lat);
        int t;
        lat = 1;
        case (ch)
            8'h0D: mc = 0;
            8'h0A: begin
                if (mr < R - 1) mr++;
                else begin m_scroll(); lat += SCR; end
            end
            8'h08: begin
                if (mc > 0) mc--;
                else if (mr > 0) begin mr--; mc = C - 1; end
            end
            8'h09: begin
                t = (mc / TW + 1) * TW;
                mc = (t > C - 1) ? C - 1 : t;
            end
            8'h0C: begin
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++)
                        exp_scr[r][c] = 8'h00;
                mr = 0; mc = 0;
                lat += R * C;
            end
            default: begin
                exp_scr[mr][mc] = ch;
                if (mc < C - 1) mc++;
                else begin
                    mc = 0;
                    if (mr < R - 1) mr++;
                    else begin m_scroll(); lat += SCR; end
                end
            end
        endcase
    endtask

    function automatic int screen_diffs();
        int n = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (mem[r * 64 + c] !== exp_scr[r][c]) n++;
        return n;
    endfunction

    task automatic send(input logic [7:0] ch, output int low,
                        output int busy);
        int w = 0;
        @(negedge clk);
        while (!o_ready && w < 5000) begin @(negedge clk); w++; end
        i_char = ch;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        low = 0;
        busy = 0;
        while (!o_ready && low < 5000) begin
            @(negedge clk);
            if (!o_ready) begin
                low++;
                if (o_busy) busy++;
            end
        end
        if (low >= 5000) low = -1;
    endtask

    task automatic do_byte(input logic [7:0] ch, output int low,
                           output int busy, output int lat);
        m_apply(ch, lat);
        send(ch, low, busy);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2048; i++) mem[i] = 8'hEE;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                exp_scr[r][c] = 8'hEE;
        rst_n = 1'b0;
        #22;
        n_total++;
        if ({o_vram_ce, o_vram_w, o_busy} !== 3'b000)
            $display("FAIL rst_strobes got %b want 000",
                     {o_vram_ce, o_vram_w, o_busy});
        else n_pass++;
        n_total++;
        if ({o_vram_addr, o_vram_din} !== 19'h0)
            $display("FAIL rst_addr_din got %h want 0",
                     {o_vram_addr, o_vram_din});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (o_ready !== 1'b1)
            $display("FAIL rst_ready got %b want 1", o_ready);
        else n_pass++;
        n_total++;
        if ({o_row, o_col} !== 11'h0)
            $display("FAIL rst_cursor got %0d/%0d want 0/0", o_row, o_col);
        else n_pass++;
    endtask

    task automatic test_put_ab();
        int low, busy, lat;
        wlog.delete();
        do_byte(8'h41, low, busy, lat);
        n_total++;
        if (low !== lat)
            $display("FAIL put_a_ready_low got %0d want %0d", low, lat);
        else n_pass++;
        do_byte(8'h42, low, busy, lat);
        n_total++;
        if (low !== lat)
            $display("FAIL put_b_ready_low got %0d want %0d", low, lat);
        else n_pass++;
        n_total++;
        if (wlog.size() !== 2)
            $display("FAIL put_count got %0d want 2", wlog.size());
        else n_pass++;
        if (wlog.size() == 2) begin
            n_total++;
            if (wlog[0] !== {11'h000, 8'h41} || wlog[1] !== {11'h001, 8'h42})
                $display("FAIL put_writes got %h %h want %h %h",
                         wlog[0], wlog[1], {11'h000, 8'h41},
                         {11'h001, 8'h42});
            else n_pass++;
        end
        n_total++;
        if (o_row !== 5'(mr) || o_col !== 6'(mc) || o_col !== 6'd2)
            $display("FAIL put_cursor got %0d/%0d want 0/2", o_row, o_col);
        else n_pass++;
    endtask

    task automatic test_clear();
        int low, busy, lat, bad;
        wlog.delete();
        do_byte(8'h0C, low, busy, lat);
        n_total++;
        if (low !== lat || busy !== R * C)
            $display("FAIL clr_timing got %0d/%0d want %0d/%0d",
                     low, busy, lat, R * C);
        else n_pass++;
        bad = (wlog.size() == R * C) ? 0 : 1;
        for (int i = 0; i < wlog.size() && i < R * C; i++)
            if (wlog[i] !== {5'(i / C), 6'(i % C), 8'h00}) bad++;
        n_total++;
        if (bad !== 0)
            $display("FAIL clr_order got %0d bad of %0d writes want 0",
                     bad, wlog.size());
        else n_pass++;
        n_total++;
        if ({o_row, o_col, o_ready} !== {11'h0, 1'b1})
            $display("FAIL clr_home got %0d/%0d rdy %b want 0/0 rdy 1",
                     o_row, o_col, o_ready);
        else n_pass++;
    endtask

    task automatic test_fill_scroll();
        int low, busy, lat, d;
        for (int i = 0; i < 11; i++) begin
            do_byte(8'h61 + 8'(i), low, busy, lat);
            n_total++;
            if (low !== lat)
                $display("FAIL fill_low[%0d] got %0d want %0d", i, low, lat);
            else n_pass++;
        end
        do_byte(8'h6C, low, busy, lat);
        n_total++;
        if (low !== 1 + SCR || busy !== SCR)
            $display("FAIL scr_timing got %0d/%0d want %0d/%0d",
                     low, busy, 1 + SCR, SCR);
        else n_pass++;
        d = screen_diffs();
        n_total++;
        if (d !== 0 || mem[0] !== 8'h65 || mem[64 + 3] !== 8'h6C)
            $display("FAIL scr_vram got %0d diffs want 0", d);
        else n_pass++;
        do_byte(8'h6D, low, busy, lat);
        n_total++;
        if (mem[2 * 64] !== 8'h6D)
            $display("FAIL scr_m got %h want 6d", mem[2 * 64]);
        else n_pass++;
        n_total++;
        if (o_row !== 5'd2 || o_col !== 6'd1)
            $display("FAIL scr_cursor got %0d/%0d want 2/1", o_row, o_col);
        else n_pass++;
    endtask

    task automatic test_edit();
        int low, busy, lat, s0;
        logic [7:0] seq [7];
        int er [7];
        int ec [7];
        seq = '{8'h0D, 8'h08, 8'h08, 8'h0D, 8'h08, 8'h0D, 8'h08};
        er  = '{2, 1, 1, 1, 0, 0, 0};
        ec  = '{0, 3, 2, 0, 3, 0, 0};
        s0 = n_strobe;
        for (int i = 0; i < 7; i++) begin
            do_byte(seq[i], low, busy, lat);
            n_total++;
            if (o_row !== 5'(er[i]) || o_col !== 6'(ec[i]) || low !== 1)
                $display("FAIL edit[%0d] got %0d/%0d lat %0d want %0d/%0d lat 1",
                         i, o_row, o_col, low, er[i], ec[i]);
            else n_pass++;
        end
        n_total++;
        if (n_strobe !== s0)
            $display("FAIL edit_strobes got %0d want %0d", n_strobe, s0);
        else n_pass++;
    endtask

    task automatic test_tab();
        int low, busy, lat;
        int ec [3];
        ec = '{2, 3, 3};
        for (int i = 0; i < 3; i++) begin
            do_byte(8'h09, low, busy, lat);
            n_total++;
            if (o_col !== 6'(ec[i]) || o_col !== 6'(mc) || o_row !== 5'd0)
                $display("FAIL tab[%0d] got %0d/%0d want 0/%0d",
                         i, o_row, o_col, ec[i]);
            else n_pass++;
        end
    endtask

    task automatic test_lf_scroll();
        int low, busy, lat, d;
        for (int i = 0; i < 3; i++) begin
            do_byte(8'h0A, low, busy, lat);
            n_total++;
            if (low !== lat || o_row !== 5'(mr) || o_col !== 6'd3)
                $display("FAIL lf[%0d] got %0d/%0d lat %0d want %0d/3 lat %0d",
                         i, o_row, o_col, low, mr, lat);
            else n_pass++;
        end
        d = screen_diffs();
        n_total++;
        if (d !== 0)
            $display("FAIL lf_vram got %0d diffs want 0", d);
        else n_pass++;
    endtask

    task automatic test_random();
        int low, busy, lat, d, k;
        logic [7:0] ch;
        logic [7:0] ctl [5];
        ctl = '{8'h0D, 8'h0A, 8'h08, 8'h09, 8'h0C};
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 19);
            if (k < 12) ch = 8'($urandom_range(8'h20, 8'h7E));
            else if (k < 19) ch = ctl[k % 4];
            else ch = ctl[4];
            do_byte(ch, low, busy, lat);
            n_total++;
            if (low !== lat || busy !== lat - 1 ||
                o_row !== 5'(mr) || o_col !== 6'(mc))
                $display("FAIL rnd[%0d] ch %h got %0d/%0d lat %0d busy %0d want %0d/%0d lat %0d",
                         i, ch, o_row, o_col, low, busy, mr, mc, lat);
            else n_pass++;
        end
        d = screen_diffs();
        n_total++;
        if (d !== 0)
            $display("FAIL rnd_vram got %0d diffs want 0", d);
        else n_pass++;
        n_total++;
        if (n_bad !== 0)
            $display("FAIL addr_range got %0d bad want 0", n_bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_scroll();
        int low, busy, lat;
        while (mr < R - 1) do_byte(8'h0A, low, busy, lat);
        @(negedge clk);
        i_char = 8'h0A;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        n_total++;
        if ({o_vram_ce, o_vram_w, o_busy} !== 3'b101)
            $display("FAIL mid_pre got %b want 101",
                     {o_vram_ce, o_vram_w, o_busy});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_vram_ce, o_vram_w, o_busy, o_ready} !== 4'b0001)
            $display("FAIL mid_async got %b want 0001",
                     {o_vram_ce, o_vram_w, o_busy, o_ready});
        else n_pass++;
        n_total++;
        if ({o_row, o_col} !== 11'h0)
            $display("FAIL mid_cursor got %0d/%0d want 0/0", o_row, o_col);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        mr = 0;
        mc = 0;
        wlog.delete();
        do_byte(8'h5A, low, busy, lat);
        n_total++;
        if (wlog.size() !== 1 || wlog[0] !== {11'h000, 8'h5A})
            $display("FAIL mid_z got %0d writes first %h want 1 %h",
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : 19'h0,
                     {11'h000, 8'h5A});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_put_ab();
        test_clear();
        test_fill_scroll();
        test_edit();
        test_tab();
        test_lf_scroll();
        test_random();
        test_reset_mid_scroll();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
